// File: rtl/single_bit_comparator_power_gated.sv
// Power-gated 1-bit magnitude comparator cell with registered one-hot outputs.
// Chain cells MSB->LSB by feeding equal_to into the next lower cell's enable.
module single_bit_comparator_power_gated #(
  parameter int unsigned WAKE_CYCLES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic a,
  input  logic b,
  output logic less_than,
  output logic equal_to,
  output logic greater_than
);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_WAKE,
    ST_ON
  } state_t;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_t;

  localparam logic [3:0] WAKE_LOAD = (WAKE_CYCLES == 0) ? 4'd0 : 4'(WAKE_CYCLES - 1);

  state_t     state_q;
  logic [3:0] cnt_q;
  cmp_t       out_q;
  cmp_t       cmp_d;

  always_comb begin
    cmp_d.lt = ~a & b;
    cmp_d.eq = ~(a ^ b);
    cmp_d.gt = a & ~b;
  end

  // NOTE: every state element uses <= so all registers update from the same
  // pre-edge values; the early out_q <= '0 is overridden by a later assignment.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      out_q <= '0;
      case (state_q)
        ST_OFF: begin
          if (enable) begin
            if (WAKE_CYCLES == 0) begin
              state_q <= ST_ON;
              out_q   <= cmp_d;
            end else begin
              state_q <= ST_WAKE;
              cnt_q   <= WAKE_LOAD;
            end
          end
        end
        ST_WAKE: begin
          if (!enable) begin
            state_q <= ST_OFF;
          end else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= ST_ON;
            out_q   <= cmp_d;
          end
        end
        ST_ON: begin
          if (enable) begin
            out_q <= cmp_d;
          end else begin
            state_q <= ST_OFF;
          end
        end
        default: state_q <= ST_OFF;
      endcase
    end
  end

  assign less_than    = out_q.lt;
  assign equal_to     = out_q.eq;
  assign greater_than = out_q.gt;

endmodule

// File: tb/tb_single_bit_comparator_power_gated.sv
// Scoreboard bench: stimulus queues hand-computed expectations per edge,
// a monitor pops and compares them just after each rising edge.
module tb_single_bit_comparator_power_gated;

  typedef enum int {K_O0, K_O3, K_CEQ, K_COR} kind_t;

  typedef struct {
    kind_t      kind;
    logic [7:0] val;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic en0, a0, b0;
  logic en3, a3, b3;
  logic ch_en;
  logic [3:0] ch_a, ch_b;

  logic lt0, eq0, gt0;
  logic lt3, eq3, gt3;
  wire  [3:0] ch_lt, ch_eq, ch_gt;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  single_bit_comparator_power_gated #(.WAKE_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(rst_n), .enable(en0), .a(a0), .b(b0),
    .less_than(lt0), .equal_to(eq0), .greater_than(gt0)
  );

  single_bit_comparator_power_gated #(.WAKE_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(rst_n), .enable(en3), .a(a3), .b(b3),
    .less_than(lt3), .equal_to(eq3), .greater_than(gt3)
  );

  for (genvar i = 0; i < 4; i++) begin : g_chain
    wire cell_en;
    if (i == 3) begin : g_top
      assign cell_en = ch_en;
    end else begin : g_low
      assign cell_en = ch_eq[i+1];
    end
    single_bit_comparator_power_gated #(.WAKE_CYCLES(0)) u_cell (
      .clk(clk), .reset(rst_n), .enable(cell_en), .a(ch_a[i]), .b(ch_b[i]),
      .less_than(ch_lt[i]), .equal_to(ch_eq[i]), .greater_than(ch_gt[i])
    );
  end

  task automatic push(input kind_t k, input logic [7:0] v, input string nm);
    exp_t e;
    e.kind = k;
    e.val  = v;
    e.name = nm;
    sb_q.push_back(e);
  endtask

  function automatic logic [7:0] actual(input kind_t k);
    case (k)
      K_O0:    return {5'b0, lt0, eq0, gt0};
      K_O3:    return {5'b0, lt3, eq3, gt3};
      K_CEQ:   return {4'b0, ch_eq};
      default: return {6'b0, |ch_lt, |ch_gt};
    endcase
  endfunction

  // Monitor: everything queued before an edge describes that edge's result.
  initial begin
    exp_t       e;
    logic [7:0] got;
    forever begin
      @(posedge clk);
      #1;
      while (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        got = actual(e.kind);
        total++;
        if (got !== e.val) begin
          bad++;
          $display("FAIL %s: got=%b expected=%b at %0t", e.name, got, e.val, $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] ab;
    logic [2:0] tt_exp [4];
    tt_exp[0] = 3'b010;
    tt_exp[1] = 3'b100;
    tt_exp[2] = 3'b001;
    tt_exp[3] = 3'b010;

    rst_n = 1'b0;
    en0 = 1'b1; a0 = 1'b1; b0 = 1'b0;
    en3 = 1'b0; a3 = 1'b0; b3 = 1'b0;
    ch_en = 1'b0; ch_a = 4'b0; ch_b = 4'b0;

    // Reset dominates enable/a/b.
    repeat (2) begin
      @(negedge clk);
      push(K_O0, 8'b000, "reset_o0");
      push(K_O3, 8'b000, "reset_o3");
      push(K_COR, 8'b00, "reset_chain_or");
    end
    @(negedge clk);
    rst_n = 1'b1;
    push(K_O0, 8'b001, "reset_release");

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ab = 2'(i);
      a0 = ab[1];
      b0 = ab[0];
      push(K_O0, {5'b0, tt_exp[i]}, $sformatf("truth_%b", ab));
    end

    // Gate off while ON with a=b=1, then wiggle inputs while gated.
    @(negedge clk);
    en0 = 1'b0;
    push(K_O0, 8'b000, "gate_off");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a0 = ~a0;
      b0 = (i == 1);
      push(K_O0, 8'b000, "gated_toggle");
    end

    a0 = 1'b1; b0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      en0 = ~en0;
      push(K_O0, en0 ? 8'b001 : 8'b000, "enable_toggle");
    end

    // Wake latency: WAKE_CYCLES+1 edges to first valid compare.
    @(negedge clk);
    en3 = 1'b1; a3 = 1'b0; b3 = 1'b1;
    push(K_O3, 8'b000, "wake_e1");
    @(negedge clk); push(K_O3, 8'b000, "wake_e2");
    @(negedge clk); push(K_O3, 8'b000, "wake_e3");
    @(negedge clk); push(K_O3, 8'b100, "wake_e4");
    @(negedge clk);
    a3 = 1'b1; b3 = 1'b1;
    push(K_O3, 8'b010, "wake_on_eq");

    // Wake abort then full restart.
    @(negedge clk);
    en3 = 1'b0;
    push(K_O3, 8'b000, "w3_gate_off");
    @(negedge clk);
    en3 = 1'b1; a3 = 1'b0; b3 = 1'b1;
    push(K_O3, 8'b000, "abort_e1");
    @(negedge clk); push(K_O3, 8'b000, "abort_e2");
    @(negedge clk);
    en3 = 1'b0;
    push(K_O3, 8'b000, "abort_drop");
    @(negedge clk);
    en3 = 1'b1;
    push(K_O3, 8'b000, "restart_e1");
    @(negedge clk); push(K_O3, 8'b000, "restart_e2");
    @(negedge clk); push(K_O3, 8'b000, "restart_e3");
    @(negedge clk); push(K_O3, 8'b100, "restart_e4");

    // Chain: A=1011, B=1001 settles to gt with bit 0 gated.
    @(negedge clk);
    ch_a = 4'b1011; ch_b = 4'b1001; ch_en = 1'b1;
    push(K_CEQ, 8'b1000, "chain1_eq_e1"); push(K_COR, 8'b00, "chain1_or_e1");
    @(negedge clk);
    push(K_CEQ, 8'b1100, "chain1_eq_e2"); push(K_COR, 8'b00, "chain1_or_e2");
    @(negedge clk);
    push(K_CEQ, 8'b1100, "chain1_eq_e3"); push(K_COR, 8'b01, "chain1_or_e3");
    @(negedge clk);
    push(K_CEQ, 8'b1100, "chain1_eq_e4"); push(K_COR, 8'b01, "chain1_or_e4");

    // Equal operands: lower cells power up one edge at a time.
    @(negedge clk);
    ch_b = 4'b1011;
    push(K_CEQ, 8'b1110, "chain2_eq_e1"); push(K_COR, 8'b00, "chain2_or_e1");
    @(negedge clk);
    push(K_CEQ, 8'b1111, "chain2_eq_e2"); push(K_COR, 8'b00, "chain2_or_e2");

    // MSB becomes less-than: lower cells power down one edge at a time.
    @(negedge clk);
    ch_a = 4'b0011;
    push(K_CEQ, 8'b0111, "chain3_eq_e1"); push(K_COR, 8'b10, "chain3_or_e1");
    @(negedge clk);
    push(K_CEQ, 8'b0011, "chain3_eq_e2"); push(K_COR, 8'b10, "chain3_or_e2");
    @(negedge clk);
    push(K_CEQ, 8'b0001, "chain3_eq_e3"); push(K_COR, 8'b10, "chain3_or_e3");
    @(negedge clk);
    push(K_CEQ, 8'b0000, "chain3_eq_e4"); push(K_COR, 8'b10, "chain3_or_e4");

    // Reset while ON clears outputs on that edge.
    @(negedge clk);
    en0 = 1'b1; a0 = 1'b0; b0 = 1'b1;
    push(K_O0, 8'b100, "pre_reset_on");
    @(negedge clk);
    rst_n = 1'b0;
    push(K_O0, 8'b000, "reset_while_on");
    push(K_COR, 8'b00, "reset_chain_clear");
    @(negedge clk);
    rst_n = 1'b1;
    push(K_O0, 8'b100, "after_reset_on");

    repeat (2) @(negedge clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got=%0d pending expected=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
